// File: rtl/riscv_mc_if.sv
// Instruction and data bus bundle for the multi-cycle core.
// Both ports use a req/ack handshake, so wait-state memories work.
interface riscv_mc_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, input imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );
    modport slave (
        input  imem_req, imem_addr, output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/riscv_mc.sv
// Multi-cycle RV32I/RV32E core: FETCH -> EXEC -> (MEM) -> FETCH, any trap parks in HALT.
module riscv_mc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          NUM_REGS     = 32,
    parameter int          COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    riscv_mc_if.master         bus,
    output logic               halted,
    output logic [2:0]         trap_cause,
    output logic [COUNT_W-1:0] instret
);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    if (!(NUM_REGS == 16 || NUM_REGS == 32)) begin : g_bad_num_regs
        $error("riscv_mc: NUM_REGS must be 16 or 32");
    end

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                           OP_BR  = 7'h63, OP_LD    = 7'h03, OP_ST  = 7'h23, OP_IMM  = 7'h13,
                           OP_OP  = 7'h33, OP_FENCE = 7'h0f, OP_SYS = 7'h73;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
    state_t state_q, state_d;

    logic [31:0]        pc_q, pc_d, ir_q;
    logic [2:0]         trap_q, trap_d;
    logic [COUNT_W-1:0] instret_q;
    logic [31:0]        regs [NUM_REGS];

    // Registered data access, held stable for the whole MEM state
    logic        mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wmask_q;
    logic [1:0]  mem_lane_q;
    logic [2:0]  mem_f3_q;
    logic [4:0]  mem_rd_q;

    // Decode fields and immediates
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rv1, rv2, pc4;
    assign opc   = ir_q[6:0];
    assign rd    = ir_q[11:7];
    assign f3    = ir_q[14:12];
    assign rs1   = ir_q[19:15];
    assign rs2   = ir_q[24:20];
    assign f7    = ir_q[31:25];
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign rv1   = (rs1 == 5'd0) ? 32'd0 : regs[rs1[RW-1:0]];
    assign rv2   = (rs2 == 5'd0) ? 32'd0 : regs[rs2[RW-1:0]];
    assign pc4   = pc_q + 32'd4;

    logic is_ld, is_st, is_ecall, is_ebreak;
    assign is_ld     = (opc == OP_LD);
    assign is_st     = (opc == OP_ST);
    assign is_ecall  = (opc == OP_SYS) && (ir_q[31:7] == 25'd0);
    assign is_ebreak = (opc == OP_SYS) && (ir_q[31:20] == 12'h001) && (ir_q[19:7] == 13'd0);

    // Opcode/funct legality and which register fields the format really uses
    logic legal, use_rd, use_rs1, use_rs2, reg_bad;
    always_comb begin
        legal   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: begin legal = 1'b1; use_rd = 1'b1; end
            OP_JALR:  begin legal = (f3 == 3'd0); use_rd = 1'b1; use_rs1 = 1'b1; end
            OP_BR:    begin legal = (f3 != 3'd2) && (f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_LD:    begin legal = (f3 != 3'd3) && (f3 < 3'd6); use_rd = 1'b1; use_rs1 = 1'b1; end
            OP_ST:    begin legal = (f3 < 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                 legal = 1'b1;
            end
            OP_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                legal  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            OP_FENCE: legal = 1'b1;
            OP_SYS:   legal = is_ecall || is_ebreak;
            default:  legal = 1'b0;
        endcase
        reg_bad = (use_rd && ({1'b0, rd} >= NREG)) || (use_rs1 && ({1'b0, rs1} >= NREG)) ||
                  (use_rs2 && ({1'b0, rs2} >= NREG));
    end

    // ALU, branch compare and control-flow target
    logic [31:0] alu_b, alu_y, ex_res, ex_tgt, ea;
    logic        br_take, ex_jmp, ea_misal;
    always_comb begin
        alu_b = (opc == OP_OP) ? rv2 : imm_i;
        case (f3)
            3'd0:    alu_y = ((opc == OP_OP) && f7[5]) ? rv1 - alu_b : rv1 + alu_b;
            3'd1:    alu_y = rv1 << alu_b[4:0];
            3'd2:    alu_y = {31'd0, $signed(rv1) < $signed(alu_b)};
            3'd3:    alu_y = {31'd0, rv1 < alu_b};
            3'd4:    alu_y = rv1 ^ alu_b;
            3'd5:    alu_y = f7[5] ? 32'($signed(rv1) >>> alu_b[4:0]) : rv1 >> alu_b[4:0];
            3'd6:    alu_y = rv1 | alu_b;
            default: alu_y = rv1 & alu_b;
        endcase
        case (f3)
            3'd0:    br_take = (rv1 == rv2);
            3'd1:    br_take = (rv1 != rv2);
            3'd4:    br_take = $signed(rv1) < $signed(rv2);
            3'd5:    br_take = $signed(rv1) >= $signed(rv2);
            3'd6:    br_take = rv1 < rv2;
            3'd7:    br_take = rv1 >= rv2;
            default: br_take = 1'b0;
        endcase
        ex_res = alu_y;
        ex_tgt = pc4;
        ex_jmp = 1'b0;
        case (opc)
            OP_LUI:   ex_res = imm_u;
            OP_AUIPC: ex_res = pc_q + imm_u;
            OP_JAL:   begin ex_res = pc4; ex_tgt = pc_q + imm_j; ex_jmp = 1'b1; end
            OP_JALR:  begin ex_res = pc4; ex_tgt = (rv1 + imm_i) & ~32'd1; ex_jmp = 1'b1; end
            OP_BR:    begin ex_jmp = br_take; if (br_take) ex_tgt = pc_q + imm_b; end
            default:  ;
        endcase
        ea       = rv1 + (is_st ? imm_s : imm_i);
        ea_misal = (f3[1:0] == 2'd1) ? ea[0] : (f3[1:0] == 2'd2) ? (ea[1:0] != 2'd0) : 1'b0;
    end

    // Store lane enables and replicated store data
    logic [3:0]  st_mask;
    logic [31:0] st_data, ld_lane, ld_val;
    always_comb begin
        case (f3[1:0])
            2'd0:    begin st_mask = 4'b0001 << ea[1:0]; st_data = {4{rv2[7:0]}};  end
            2'd1:    begin st_mask = 4'b0011 << ea[1:0]; st_data = {2{rv2[15:0]}}; end
            default: begin st_mask = 4'b1111;            st_data = rv2;            end
        endcase
    end

    // Load lane select with sign/zero extension
    always_comb begin
        ld_lane = bus.dmem_rdata >> {mem_lane_q, 3'b000};
        case (mem_f3_q)
            3'd0:    ld_val = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'd1:    ld_val = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'd4:    ld_val = {24'd0, ld_lane[7:0]};
            3'd5:    ld_val = {16'd0, ld_lane[15:0]};
            default: ld_val = bus.dmem_rdata;
        endcase
    end

    // Next-state, trap selection, retire and register writeback
    logic       rf_we, retire, mem_go;
    logic [4:0] rf_rd;
    logic [31:0] rf_wd;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        trap_d  = trap_q;
        rf_we   = 1'b0;
        rf_rd   = rd;
        rf_wd   = ex_res;
        retire  = 1'b0;
        mem_go  = 1'b0;
        case (state_q)
            S_FETCH: if (bus.imem_ack) state_d = S_EXEC;
            S_EXEC: begin
                if (!legal || reg_bad)                 begin trap_d = 3'd1; state_d = S_HALT; end
                else if (is_ecall)                     begin trap_d = 3'd4; state_d = S_HALT; end
                else if (is_ebreak)                    begin trap_d = 3'd5; state_d = S_HALT; end
                else if (ex_jmp && ex_tgt[1])          begin trap_d = 3'd2; state_d = S_HALT; end
                else if ((is_ld || is_st) && ea_misal) begin trap_d = 3'd3; state_d = S_HALT; end
                else if (is_ld || is_st)               begin mem_go = 1'b1; state_d = S_MEM; end
                else begin
                    rf_we   = use_rd;
                    pc_d    = ex_tgt;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: if (bus.dmem_ack) begin
                rf_we   = !mem_we_q;
                rf_rd   = mem_rd_q;
                rf_wd   = ld_val;
                pc_d    = pc4;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // PC, IR, trap cause, retire counter and the latched data access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_VECTOR;
            ir_q        <= '0;
            trap_q      <= '0;
            instret_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            mem_lane_q  <= '0;
            mem_f3_q    <= '0;
            mem_rd_q    <= '0;
        end else begin
            pc_q   <= pc_d;
            trap_q <= trap_d;
            if (retire) instret_q <= instret_q + COUNT_W'(1);
            if (state_q == S_FETCH && bus.imem_ack) ir_q <= bus.imem_rdata;
            if (mem_go) begin
                mem_we_q    <= is_st;
                mem_addr_q  <= {ea[31:2], 2'b00};
                mem_lane_q  <= ea[1:0];
                mem_f3_q    <= f3;
                mem_rd_q    <= rd;
                mem_wmask_q <= st_mask;
                mem_wdata_q <= st_data;
            end
        end
    end

    // Register file; x0 writes are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (rf_we && rf_rd != 5'd0) begin
            regs[rf_rd[RW-1:0]] <= rf_wd;
        end
    end

    // imem_req is gated by reset so it reads 0 while rst_n is held low
    assign bus.imem_req   = rst_n && (state_q == S_FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = (state_q == S_MEM);
    assign bus.dmem_we    = (state_q == S_MEM) && mem_we_q;
    assign bus.dmem_addr  = mem_addr_q;
    assign bus.dmem_wmask = ((state_q == S_MEM) && mem_we_q) ? mem_wmask_q : 4'b0000;
    assign bus.dmem_wdata = mem_wdata_q;
    assign halted         = (state_q == S_HALT);
    assign trap_cause     = trap_q;
    assign instret        = instret_q;
endmodule

// File: tb/tb_riscv_mc.sv
// Directed bench for riscv_mc: table of short ALU programs plus hand sequences
// for loads/stores, wait states, traps, RV32E and mid-transaction reset.
module tb_riscv_mc;
    logic clk = 1'b0, rst_n = 1'b0, rst_e_n = 1'b0;
    always #5 clk = ~clk;

    riscv_mc_if bus();
    riscv_mc_if ebus();
    logic        halted, e_halted;
    logic [2:0]  trap_cause, e_trap;
    logic [31:0] instret, e_instret;

    riscv_mc #(.RESET_VECTOR(32'h100), .NUM_REGS(32), .COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .halted(halted), .trap_cause(trap_cause), .instret(instret));
    riscv_mc #(.RESET_VECTOR(32'h0), .NUM_REGS(16), .COUNT_W(32)) dut_e (
        .clk(clk), .rst_n(rst_e_n), .bus(ebus), .halted(e_halted), .trap_cause(e_trap), .instret(e_instret));

    // Memory model for the main core: zero-wait fetch, programmable data wait states
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    int dwait = 0;
    int wcnt  = 0;
    assign bus.imem_ack   = bus.imem_req;
    assign bus.imem_rdata = imem[bus.imem_addr[9:2]];
    assign bus.dmem_ack   = bus.dmem_req && (wcnt >= dwait);
    assign bus.dmem_rdata = dmem[bus.dmem_addr[9:2]];
    always @(posedge clk) wcnt <= (bus.dmem_req && !bus.dmem_ack) ? wcnt + 1 : 0;

    // Transaction monitor and store write-back, sampled on the falling edge
    int reqcyc = 0, cur_cyc = 0, nlog = 0, unstable = 0;
    logic [31:0] p_addr, p_data;
    logic [3:0]  p_mask;
    logic        p_we;
    logic [31:0] lg_addr [16];
    logic [31:0] lg_data [16];
    logic [3:0]  lg_mask [16];
    int          lg_cyc  [16];
    always @(negedge clk) begin
        if (bus.dmem_req) begin
            reqcyc++;
            cur_cyc++;
            if (cur_cyc > 1 && (bus.dmem_addr != p_addr || bus.dmem_we != p_we ||
                                bus.dmem_wmask != p_mask || bus.dmem_wdata != p_data)) unstable++;
            p_addr = bus.dmem_addr; p_we = bus.dmem_we; p_mask = bus.dmem_wmask; p_data = bus.dmem_wdata;
            if (bus.dmem_ack) begin
                if (nlog < 16) begin
                    lg_addr[nlog] = bus.dmem_addr; lg_data[nlog] = bus.dmem_wdata;
                    lg_mask[nlog] = bus.dmem_wmask; lg_cyc[nlog] = cur_cyc;
                end
                nlog++;
                cur_cyc = 0;
                if (bus.dmem_we)
                    for (int b = 0; b < 4; b++)
                        if (bus.dmem_wmask[b]) dmem[bus.dmem_addr[9:2]][8*b +: 8] = bus.dmem_wdata[8*b +: 8];
            end
        end else cur_cyc = 0;
    end

    // RV32E core memory: zero-wait both ports
    logic [31:0] eimem [64];
    logic [31:0] edmem [64];
    assign ebus.imem_ack   = ebus.imem_req;
    assign ebus.imem_rdata = eimem[ebus.imem_addr[7:2]];
    assign ebus.dmem_ack   = ebus.dmem_req;
    assign ebus.dmem_rdata = edmem[ebus.dmem_addr[7:2]];
    always @(negedge clk)
        if (ebus.dmem_req && ebus.dmem_we)
            for (int b = 0; b < 4; b++)
                if (ebus.dmem_wmask[b]) edmem[ebus.dmem_addr[7:2]][8*b +: 8] = ebus.dmem_wdata[8*b +: 8];

    // Encoders
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(7'h13, 3'd0, rd, rs1, imm);
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013, ECALL = 32'h0000_0073, EBREAK = 32'h0010_0073;

    int ntest = 0, nfail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin imem[i] = ECALL; dmem[i] = 32'd0; end
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        reqcyc = 0; nlog = 0; unstable = 0;
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input string nm, input int maxc);
        int c = 0;
        while (!halted && c < maxc) begin @(negedge clk); c++; end
        if (!halted) begin
            ntest++; nfail++;
            $display("FAIL %s: timeout, halted=0 expected 1", nm);
        end
    endtask

    typedef struct {
        logic [31:0] i0, i1, i2;
        logic [31:0] exp_val;
        logic [31:0] exp_ret;
    } vec_t;
    vec_t vecs [12];

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  cause;
    } trap_t;
    trap_t traps [8];

    initial begin
        // i0,i1,i2 at 0x100..0x108, then sw x3,0x40(x0); ecall
        vecs[0]  = '{addi(1,0,12'd5), addi(2,1,12'hFF9), enc_r(7'h20,2,1,3'd0,3), 32'h7, 32'd4};
        vecs[1]  = '{addi(1,0,12'hFF0), enc_i(7'h13,3'd5,3,1,12'h402), NOP, 32'hFFFF_FFFC, 32'd4};
        vecs[2]  = '{addi(1,0,12'hFF0), enc_i(7'h13,3'd5,3,1,12'h01C), NOP, 32'h0000_000F, 32'd4};
        vecs[3]  = '{enc_u(7'h37,1,20'h12345), addi(3,1,12'h678), NOP, 32'h1234_5678, 32'd4};
        vecs[4]  = '{addi(1,0,12'hFFF), addi(2,0,12'd1), enc_r(7'h00,1,2,3'd3,3), 32'h1, 32'd4};
        vecs[5]  = '{addi(1,0,12'hFFF), addi(2,0,12'd1), enc_r(7'h00,2,1,3'd2,3), 32'h1, 32'd4};
        vecs[6]  = '{addi(1,0,12'd3), addi(2,0,12'd5), enc_r(7'h00,2,1,3'd4,3), 32'h6, 32'd4};
        vecs[7]  = '{addi(1,0,12'h0F0), enc_i(7'h13,3'd6,3,1,12'h00F), NOP, 32'hFF, 32'd4};
        vecs[8]  = '{addi(1,0,12'd1), addi(2,0,12'd7), enc_r(7'h00,2,1,3'd1,3), 32'h80, 32'd4};
        vecs[9]  = '{enc_u(7'h17,3,20'h00001), NOP, NOP, 32'h1100, 32'd4};
        vecs[10] = '{enc_j(3,21'd8), addi(3,0,12'd99), NOP, 32'h104, 32'd3};
        vecs[11] = '{addi(3,0,12'd11), enc_b(13'd8,0,0,3'd1), addi(3,3,12'd1), 32'd12, 32'd4};

        traps[0] = '{enc_i(7'h03,3'd2,1,0,12'd2), 3'd3};   // lw x1,2(x0)
        traps[1] = '{ECALL, 3'd4};
        traps[2] = '{EBREAK, 3'd5};
        traps[3] = '{32'h0000_0000, 3'd1};                  // unknown opcode
        traps[4] = '{enc_j(0,21'd6), 3'd2};                 // jal to 0x106
        traps[5] = '{enc_r(7'h01,2,1,3'd0,3), 3'd1};        // bad funct7
        traps[6] = '{enc_i(7'h67,3'd0,1,0,12'd3), 3'd2};    // jalr -> 2
        traps[7] = '{enc_s(12'd1,0,0,3'd1), 3'd3};          // sh at 1

        // Reset state and first-program latency
        clear_mem();
        imem[64] = vecs[0].i0; imem[65] = vecs[0].i1; imem[66] = vecs[0].i2;
        @(negedge clk);
        check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        check("rst_wmask", {28'd0, bus.dmem_wmask}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_trap", {29'd0, trap_cause}, 32'd0);
        check("rst_instret", instret, 32'd0);
        rst_n = 1'b1;
        #1;
        check("first_imem_addr", bus.imem_addr, 32'h100);
        check("first_imem_req", {31'd0, bus.imem_req}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("instret_6cyc", instret, 32'd3);

        // ALU program table
        for (int v = 0; v < 12; v++) begin
            clear_mem();
            imem[64] = vecs[v].i0; imem[65] = vecs[v].i1; imem[66] = vecs[v].i2;
            imem[67] = enc_s(12'h040, 3, 0, 3'd2);
            restart();
            run_to_halt($sformatf("vec%0d_halt", v), 60);
            check($sformatf("vec%0d_val", v), dmem[16], vecs[v].exp_val);
            check($sformatf("vec%0d_instret", v), instret, vecs[v].exp_ret);
            check($sformatf("vec%0d_trap", v), {29'd0, trap_cause}, 32'd4);
        end

        // Byte/half stores with lane replication, sign/zero-extended loads
        clear_mem();
        imem[64] = addi(5, 0, 12'h080);
        imem[65] = enc_s(12'h021, 5, 0, 3'd0);
        imem[66] = enc_i(7'h03, 3'd0, 6, 0, 12'h021);
        imem[67] = enc_i(7'h03, 3'd4, 7, 0, 12'h021);
        imem[68] = enc_i(7'h03, 3'd1, 8, 0, 12'h020);
        imem[69] = enc_i(7'h03, 3'd5, 9, 0, 12'h020);
        imem[70] = enc_s(12'h052, 5, 0, 3'd1);
        imem[71] = enc_s(12'h040, 6, 0, 3'd2);
        imem[72] = enc_s(12'h044, 7, 0, 3'd2);
        imem[73] = enc_s(12'h048, 8, 0, 3'd2);
        imem[74] = enc_s(12'h04C, 9, 0, 3'd2);
        restart();
        run_to_halt("ldst_halt", 100);
        check("sb_addr", lg_addr[0], 32'h20);
        check("sb_wmask", {28'd0, lg_mask[0]}, 32'h2);
        check("sb_wdata", lg_data[0], 32'h8080_8080);
        check("sh_wmask", {28'd0, lg_mask[5]}, 32'hC);
        check("sh_wdata", lg_data[5], 32'h0080_0080);
        check("mem20", dmem[8], 32'h0000_8000);
        check("mem50", dmem[20], 32'h0080_0000);
        check("lb", dmem[16], 32'hFFFF_FF80);
        check("lbu", dmem[17], 32'h0000_0080);
        check("lh", dmem[18], 32'hFFFF_8000);
        check("lhu", dmem[19], 32'h0000_8000);
        check("ldst_instret", instret, 32'd11);

        // Data wait states
        clear_mem();
        dmem[18] = 32'hCAFE_BABE;
        imem[64] = enc_i(7'h03, 3'd2, 8, 0, 12'h048);
        imem[65] = enc_s(12'h04C, 8, 0, 3'd2);
        dwait = 3;
        restart();
        run_to_halt("wait_halt", 100);
        check("wait_lw_cycles", 32'(lg_cyc[0]), 32'd4);
        check("wait_sw_cycles", 32'(lg_cyc[1]), 32'd4);
        check("wait_stable", 32'(unstable), 32'd0);
        check("wait_data", dmem[19], 32'hCAFE_BABE);
        check("wait_instret", instret, 32'd2);
        dwait = 0;

        // Traps: no retire, no data access
        for (int t = 0; t < 8; t++) begin
            clear_mem();
            imem[64] = traps[t].instr;
            restart();
            run_to_halt($sformatf("trap%0d_halt", t), 20);
            check($sformatf("trap%0d_cause", t), {29'd0, trap_cause}, {29'd0, traps[t].cause});
            check($sformatf("trap%0d_instret", t), instret, 32'd0);
            check($sformatf("trap%0d_noreq", t), 32'(reqcyc), 32'd0);
            check($sformatf("trap%0d_reqs", t), {30'd0, bus.imem_req, bus.dmem_req}, 32'd0);
        end

        // RV32E: x15 legal, x20 traps
        for (int i = 0; i < 64; i++) begin eimem[i] = ECALL; edmem[i] = 32'd0; end
        eimem[0] = addi(15, 0, 12'd1);
        eimem[1] = enc_s(12'h040, 15, 0, 3'd2);
        eimem[2] = addi(20, 0, 12'd1);
        @(negedge clk);
        rst_e_n = 1'b1;
        for (int c = 0; c < 40 && !e_halted; c++) @(negedge clk);
        check("e_halted", {31'd0, e_halted}, 32'd1);
        check("e_x15", edmem[16], 32'd1);
        check("e_trap", {29'd0, e_trap}, 32'd1);
        check("e_instret", e_instret, 32'd2);

        // Reset while a load waits for ack
        clear_mem();
        imem[64] = addi(9, 0, 12'd55);
        imem[65] = enc_i(7'h03, 3'd2, 1, 0, 12'h048);
        dwait = 1000;
        restart();
        for (int c = 0; c < 20 && !bus.dmem_req; c++) @(negedge clk);
        check("mid_req_seen", {31'd0, bus.dmem_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        dmem[20] = 32'hDEAD_BEEF;
        imem[64] = enc_s(12'h050, 9, 0, 3'd2);
        imem[65] = NOP;
        imem[66] = enc_b(13'h1FF8, 0, 0, 3'd0);
        dwait = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_instret", instret, 32'd0);
        check("mid_imem_addr", bus.imem_addr, 32'h100);
        for (int c = 0; c < 40 && instret != 32'd3; c++) @(negedge clk);
        check("beq_instret", instret, 32'd3);
        check("beq_target", bus.imem_addr, 32'h100);
        check("mid_regs_cleared", dmem[20], 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
